// File: rtl/beep_sequencer.sv
// Turns a one-cycle request strobe into timed buzzer beeps with a fixed tone.
// A one-deep pending slot queues one extra request that arrives while a sequence is running.
module beep_sequencer #(
  parameter int unsigned MS_DIV    = 50000,
  parameter int unsigned TONE_HALF = 12500,
  parameter int unsigned BEEP_MS   = 100,
  parameter int unsigned GAP_MS    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beep_req,
  input  logic [2:0] beep_count,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PH_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
  localparam int unsigned MS_W   = (MS_DIV > 1)    ? $clog2(MS_DIV)    : 1;
  localparam int unsigned TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int unsigned PH_W   = (PH_MAX > 1)    ? $clog2(PH_MAX)    : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;
  logic [2:0]        remain_q, remain_d;
  logic              pend_valid_q, pend_valid_d;
  logic [2:0]        pend_cnt_q, pend_cnt_d;

  logic       ms_tick;
  logic       on_end;
  logic       gap_end;
  logic [2:0] req_cnt;

  assign req_cnt = (beep_count == 3'd0) ? 3'd1 : beep_count;
  assign ms_tick = (ms_cnt_q == MS_W'(MS_DIV - 1));
  assign on_end  = (state_q == S_ON)  && ms_tick && (phase_q == PH_W'(BEEP_MS - 1));
  assign gap_end = (state_q == S_GAP) && ms_tick && (phase_q == PH_W'(GAP_MS - 1));

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d      = state_q;
    ms_cnt_d     = ms_tick ? '0 : ms_cnt_q + 1'b1;
    phase_d      = ms_tick ? phase_q + 1'b1 : phase_q;
    tone_cnt_d   = tone_cnt_q + 1'b1;
    tone_d       = tone_q;
    remain_d     = remain_q;
    pend_valid_d = pend_valid_q;
    pend_cnt_d   = pend_cnt_q;
    done         = 1'b0;

    if (tone_cnt_q == TONE_W'(TONE_HALF - 1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end

    // A request while busy fills the slot only if it is empty; otherwise it is dropped.
    if (beep_req && (state_q != S_IDLE) && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_cnt_d   = req_cnt;
    end

    case (state_q)
      S_IDLE: begin
        ms_cnt_d = '0;
        phase_d  = '0;
        if (beep_req) begin
          remain_d   = req_cnt;
          state_d    = S_ON;
          tone_cnt_d = '0;
          tone_d     = 1'b1;
        end
      end

      S_ON: begin
        if (on_end) begin
          ms_cnt_d = '0;
          phase_d  = '0;
          if (remain_q > 3'd1) begin
            remain_d = remain_q - 3'd1;
            state_d  = S_GAP;
          end else begin
            done = 1'b1;
            if (pend_valid_q) begin
              remain_d     = pend_cnt_q;
              pend_valid_d = 1'b0;
              state_d      = S_GAP;
            end else if (beep_req) begin
              // A request colliding with the final edge chains straight on, bypassing the slot.
              remain_d     = req_cnt;
              pend_valid_d = 1'b0;
              state_d      = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_end) begin
          state_d    = S_ON;
          ms_cnt_d   = '0;
          phase_d    = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      ms_cnt_q     <= '0;
      phase_q      <= '0;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      remain_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ms_cnt_q     <= ms_cnt_d;
      phase_q      <= phase_d;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      remain_q     <= remain_d;
      pend_valid_q <= pend_valid_d;
      pend_cnt_q   <= pend_cnt_d;
    end
  end

  // Only mute gates the registered tone; timing never depends on it.
  assign buzzer = tone_q & (state_q == S_ON) & ~mute;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_beep_sequencer.sv
// Table-driven bench for beep_sequencer: per-cycle vectors of stimulus and expected
// {buzzer, busy, done}, built from phase helpers at small timing parameters.
module tb_beep_sequencer;

  localparam int unsigned MS_DIV    = 10;
  localparam int unsigned TONE_HALF = 2;
  localparam int unsigned BEEP_MS   = 3;
  localparam int unsigned GAP_MS    = 2;
  localparam int ON_CYC  = BEEP_MS * MS_DIV;
  localparam int GAP_CYC = GAP_MS * MS_DIV;
  localparam int MAX_VEC = 2048;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [2:0] cnt;
    logic       mute;
    logic       exp_buz;
    logic       exp_busy;
    logic       exp_done;
    int         scn;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       beep_req;
  logic [2:0] beep_count;
  logic       mute;
  logic       buzzer;
  logic       busy;
  logic       done;

  vec_t vecs [MAX_VEC];
  int   n_vec  = 0;
  int   scn_id = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  beep_sequencer #(
    .MS_DIV   (MS_DIV),
    .TONE_HALF(TONE_HALF),
    .BEEP_MS  (BEEP_MS),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .beep_req  (beep_req),
    .beep_count(beep_count),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {buzzer,busy,done} got %b want %b", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic bu, input logic d, input logic m);
    vecs[n_vec] = '{rst: 1'b0, req: 1'b0, cnt: 3'd0, mute: m,
                    exp_buz: b, exp_busy: bu, exp_done: d, scn: scn_id};
    n_vec++;
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected ON phase: tone starts high and flips every TONE_HALF cycles; mute only gates it.
  task automatic add_on(input int len, input int m_lo, input int m_hi, input logic last);
    logic m;
    logic b;
    for (int k = 0; k < len; k++) begin
      m = (k >= m_lo) && (k < m_hi);
      b = (((k / TONE_HALF) % 2) == 0) && !m;
      push(b, 1'b1, last && (k == ON_CYC - 1), m);
    end
  endtask

  task automatic add_gap();
    for (int i = 0; i < GAP_CYC; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_req(input int idx, input int c);
    vecs[idx].req = 1'b1;
    vecs[idx].cnt = 3'(c);
  endtask

  task automatic build();
    int s;
    int o;
    // 1: single beep, request on cycle 5, beep on cycles 6..35
    scn_id = 1; s = n_vec;
    add_idle(6); set_req(s + 5, 1);
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 2: count 3 -> ON/GAP/ON/GAP/ON, one done
    scn_id = 2; s = n_vec;
    add_idle(2); set_req(s + 1, 3);
    add_on(ON_CYC, 0, 0, 1'b0); add_gap();
    add_on(ON_CYC, 0, 0, 1'b0); add_gap();
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 3: count 0 behaves as count 1
    scn_id = 3; s = n_vec;
    add_idle(2); set_req(s + 1, 0);
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 4: count 0 fully muted: silent, same busy/done timing
    scn_id = 4; s = n_vec;
    add_idle(2); set_req(s + 1, 0);
    add_on(ON_CYC, 0, ON_CYC, 1'b1); add_idle(4);
    // 5: mute toggled mid-beep leaves durations unchanged
    scn_id = 5; s = n_vec;
    add_idle(2); set_req(s + 1, 2);
    add_on(ON_CYC, 7, 19, 1'b0); add_gap();
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 6: pending queue: second request queued, third dropped
    scn_id = 6; s = n_vec;
    add_idle(2); set_req(s + 1, 2);
    o = n_vec; add_on(ON_CYC, 0, 0, 1'b0);
    set_req(o + 5, 1); set_req(o + 8, 3);
    add_gap(); add_on(ON_CYC, 0, 0, 1'b1);
    add_gap(); add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 7: two-cycle request pulse fills the slot once
    scn_id = 7; s = n_vec;
    add_idle(2); set_req(s + 1, 1);
    o = n_vec; add_on(ON_CYC, 0, 0, 1'b1);
    set_req(o + 10, 2); set_req(o + 11, 2);
    add_gap(); add_on(ON_CYC, 0, 0, 1'b0);
    add_gap(); add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 8: reset in the 15th ON cycle, then a fresh full beep
    scn_id = 8; s = n_vec;
    add_idle(2); set_req(s + 1, 1);
    add_on(15, 0, 0, 1'b0); vecs[n_vec - 1].rst = 1'b1;
    add_idle(3); set_req(n_vec - 1, 1);
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 9: request on the done cycle chains into GAP then ON
    scn_id = 9; s = n_vec;
    add_idle(2); set_req(s + 1, 1);
    o = n_vec; add_on(ON_CYC, 0, 0, 1'b1);
    set_req(o + ON_CYC - 1, 1);
    add_gap(); add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
    // 10: maximum count 7
    scn_id = 10; s = n_vec;
    add_idle(2); set_req(s + 1, 7);
    for (int i = 0; i < 6; i++) begin
      add_on(ON_CYC, 0, 0, 1'b0); add_gap();
    end
    add_on(ON_CYC, 0, 0, 1'b1); add_idle(4);
  endtask

  initial begin
    build();
    rst        = 1'b1;
    beep_req   = 1'b1;
    beep_count = 3'd3;
    mute       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", {buzzer, busy, done}, 3'b000);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      beep_req   = vecs[i].req;
      beep_count = vecs[i].cnt;
      mute       = vecs[i].mute;
      #1;
      check($sformatf("scn%0d_v%0d", vecs[i].scn, i), {buzzer, busy, done},
            {vecs[i].exp_buz, vecs[i].exp_busy, vecs[i].exp_done});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
